// File: rtl/key_scan_if.sv
// Key front-end bundle: raw buttons in, press pulses, debounced levels and
// arbiter-busy out.
interface key_scan_if;
   logic [4:0] key_raw;
   logic [4:0] key;
   logic [4:0] held;
   logic       busy;

   modport master (
      output key_raw,
      input  key,
      input  held,
      input  busy
   );

   modport slave (
      input  key_raw,
      output key,
      output held,
      output busy
   );
endinterface

// File: rtl/key_scan.sv
// Push-button front-end: two-flop synchroniser, per-key debounce, priority
// arbiter with single-owner press pulses and UP/DOWN auto-repeat.
module key_scan #(
   parameter int unsigned DEB_CYCLES    = 2,
   parameter int unsigned REPEAT_DELAY  = 50,
   parameter int unsigned REPEAT_PERIOD = 10,
   parameter logic [4:0]  REPEAT_MASK   = 5'b00011,
   parameter bit          ACTIVE_LOW    = 1'b0
) (
   input logic       CLK,
   input logic       RESETN,
   key_scan_if.slave bus_io
);

   localparam logic [7:0] DebLimit  = 8'(DEB_CYCLES);
   localparam logic [7:0] RepDelay  = 8'(REPEAT_DELAY);
   localparam logic [7:0] RepPeriod = 8'(REPEAT_PERIOD);
   localparam logic [4:0] OneHotLsb = 5'b00001;

   typedef enum logic [1:0] {
      StIdle,
      StOwn,
      StWaitRel
   } state_e;

   logic [4:0]      raw_in;
   logic [4:0]      sync1_q, sync2_q;
   logic [4:0]      held_q, held_d, held_prev_q;
   logic [4:0][7:0] deb_cnt_q, deb_cnt_d;
   logic [4:0]      rise;
   logic [2:0]      win_idx;

   state_e     state_q;
   logic [2:0] owner_q;
   logic [7:0] rep_cnt_q;
   logic [4:0] key_q;
   logic       busy_q;

   assign raw_in = ACTIVE_LOW ? ~bus_io.key_raw : bus_io.key_raw;

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         held_q      <= '0;
         held_prev_q <= '0;
         deb_cnt_q   <= '0;
      end else begin
         sync1_q     <= raw_in;
         sync2_q     <= sync1_q;
         held_q      <= held_d;
         held_prev_q <= held_q;
         deb_cnt_q   <= deb_cnt_d;
      end
   end

   // Counter only runs while the synced level disagrees with the debounced one,
   // and clears on the cycle it commits, so it never passes DebLimit.
   always_comb begin
      held_d    = held_q;
      deb_cnt_d = '0;
      for (int i = 0; i < 5; i++) begin
         if (sync2_q[i] != held_q[i]) begin
            if (deb_cnt_q[i] + 8'd1 == DebLimit) begin
               held_d[i] = sync2_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
            end
         end
      end
   end

   assign rise = held_q & ~held_prev_q;

   // Ascending scan: the highest set index (MENU) wins.
   always_comb begin
      win_idx = 3'd0;
      for (int i = 0; i < 5; i++) begin
         if (rise[i]) begin
            win_idx = 3'(i);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_q   <= StIdle;
         owner_q   <= '0;
         rep_cnt_q <= '0;
         key_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         key_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (|rise) begin
                  owner_q   <= win_idx;
                  key_q     <= OneHotLsb << win_idx;
                  rep_cnt_q <= RepDelay;
                  busy_q    <= 1'b1;
                  state_q   <= StOwn;
               end
            end
            StOwn: begin
               // Looking at the level being committed this edge lets a
               // simultaneous release suppress a due repeat pulse.
               if (!held_d[owner_q]) begin
                  state_q <= StWaitRel;
               end else if (REPEAT_MASK[owner_q]) begin
                  if (rep_cnt_q == 8'd1) begin
                     key_q     <= OneHotLsb << owner_q;
                     rep_cnt_q <= RepPeriod;
                  end else begin
                     rep_cnt_q <= rep_cnt_q - 8'd1;
                  end
               end
            end
            StWaitRel: begin
               if (held_q == '0) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus_io.key  = key_q;
   assign bus_io.held = held_q;
   assign bus_io.busy = busy_q;

endmodule
